// File: rtl/fifo_mem.sv
// Simple dual-port register array for the FIFO: one write port and one
// registered read port whose output holds when no read is requested.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  // Storage is left uninitialised; only the output register is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO keeping the legacy async_fifo port set: pointers, an
// occupancy count, flags decoded from that count, write ack and read valid.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ALMOST_WR  = 2,
  parameter int ALMOST_RD  = 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH-1)+1,
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  wr_ack,
  output logic                  valid,
  output logic [CNT_W-1:0]      wr_count,
  output logic [CNT_W-1:0]      rd_count
);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             wr_ack_reg;
  logic             valid_reg;
  logic             wr_accept;
  logic             rd_accept;

  // Acceptance uses the registered flags, so a full FIFO refuses a write even
  // when a read frees a slot in the same cycle (and likewise for empty).
  assign wr_accept = wr_en & ~full & ~rst;
  assign rd_accept = rd_en & ~empty & ~rst;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_accept) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    if (wr_accept && !rd_accept) begin
      count_next = count_reg + CNT_W'(1);
    end else if (rd_accept && !wr_accept) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      wr_ack_reg <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      wr_ack_reg <= wr_accept;
      valid_reg  <= rd_accept;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .ADDR_W    (PTR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_accept),
    .waddr(wr_ptr_reg),
    .wdata(din),
    .re   (rd_accept),
    .raddr(rd_ptr_reg),
    .rdata(dout)
  );

  assign full         = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= CNT_W'(FIFO_DEPTH - ALMOST_WR));
  assign almost_empty = (count_reg <= CNT_W'(ALMOST_RD));
  assign wr_ack       = wr_ack_reg;
  assign valid        = valid_reg;
  assign wr_count     = count_reg;
  assign rd_count     = count_reg;

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: directed plan sequences plus random traffic
// against a queue-based reference model; a negedge monitor does the checking.
module tb_async_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AWR   = 2;
  localparam int ARD   = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty, wr_ack, valid;
  logic [3:0]    wr_count, rd_count;

  async_fifo #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ALMOST_WR(AWR), .ALMOST_RD(ARD)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .wr_ack(wr_ack), .valid(valid),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // Reference model state, updated at each rising edge by the driver.
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_dout = '0;
  bit            exp_ack = 0;
  bit            exp_valid = 0;
  bit            mon_on = 0;
  int            vectors = 0;
  int            checks = 0;
  int            miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit w, input logic [DW-1:0] d,
                            input bit rd);
    bit wa, ra;
    logic [DW-1:0] v;
    if (r) begin
      model_q.delete();
      exp_ack = 0;
      exp_valid = 0;
      exp_dout = '0;
    end else begin
      wa = w && (model_q.size() < DEPTH);
      ra = rd && (model_q.size() > 0);
      if (ra) begin
        v = model_q.pop_front();
        exp_q.push_back(v);
        exp_dout = v;
      end
      if (wa) model_q.push_back(d);
      exp_ack = wa;
      exp_valid = ra;
    end
  endtask

  // One clock: drive, let the edge happen, update the model, step off the edge.
  task automatic cyc(input bit r, input bit w, input int d, input bit rd);
    logic [DW-1:0] dt;
    dt = d[DW-1:0];
    rst = r; wr_en = w; din = dt; rd_en = rd;
    @(posedge clk);
    model_step(r, w, dt, rd);
    vectors++;
    #1;
    mon_on = 1;
  endtask

  initial begin : monitor
    int n;
    logic [DW-1:0] v;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        n = model_q.size();
        chk("wr_ack", int'(wr_ack), int'(exp_ack));
        chk("valid", int'(valid), int'(exp_valid));
        chk("dout_hold", int'(dout), int'(exp_dout));
        chk("wr_count", int'(wr_count), n);
        chk("rd_count", int'(rd_count), n);
        chk("full", int'(full), int'(n == DEPTH));
        chk("empty", int'(empty), int'(n == 0));
        chk("almost_full", int'(almost_full), int'(n >= DEPTH - AWR));
        chk("almost_empty", int'(almost_empty), int'(n <= ARD));
        if (valid) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_underrun", 1, 0);
          end else begin
            v = exp_q.pop_front();
            chk("read_data", int'(dout), int'(v));
          end
        end
        $display("cyc %0d rst=%0b wr=%0b din=%0d rd=%0b -> dout=%0d valid=%0b ack=%0b cnt=%0d",
                 vectors, rst, wr_en, din, rd_en, dout, valid, wr_ack, wr_count);
      end
    end
  end

  initial begin : driver
    int wvals [10];
    wvals[0] = 17; wvals[1] = 20;
    for (int i = 0; i < 8; i++) wvals[i+2] = 800 + i;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    for (int i = 0; i < 10; i++) cyc(0, 1, wvals[i], 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1);

    for (int i = 1; i <= 10; i++) cyc(0, 1, i, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1);

    for (int i = 0; i < 4; i++) cyc(0, 1, 50 + i, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 60 + i, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 70 + i, 0);
    cyc(0, 1, 99, 1);

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 123, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
Single-clock FIFO with the codebase's FIFO interface: write port, read port, status flags, acknowledges and occupancy counts. It buffers FIFO_DEPTH words of DATA_WIDTH bits between a producer and a consumer in the same clock domain. It keeps the codebase's async_fifo interface so existing instantiations connect unchanged, except that one clock replaces the write and read clocks.

Parameters:
DATA_WIDTH, 8, word width in bits.
FIFO_DEPTH, 8, number of entries; must be a power of two and at least 4.
ALMOST_WR, 2, almost_full asserts when free entries <= ALMOST_WR; range 1..FIFO_DEPTH-1.
ALMOST_RD, 1, almost_empty asserts when occupancy <= ALMOST_RD; range 1..FIFO_DEPTH-1.

Ports:
clk  in  1  single clock; every register is rising-edge triggered.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write request.
din  in  DATA_WIDTH  write data.
rd_en  in  1  read request.
dout  out  DATA_WIDTH  read data, registered.
full  out  1  occupancy == FIFO_DEPTH.
empty  out  1  occupancy == 0.
almost_full  out  1  occupancy >= FIFO_DEPTH-ALMOST_WR.
almost_empty  out  1  occupancy <= ALMOST_RD.
wr_ack  out  1  previous-cycle write was accepted.
valid  out  1  dout carries data from a read accepted in the previous cycle.
wr_count  out  $clog2(FIFO_DEPTH-1)+1  occupancy (4 bits at the default depth).
rd_count  out  $clog2(FIFO_DEPTH-1)+1  occupancy, identical to wr_count.

Behaviour:
- Reset: one clock with rst=1 clears the pointers and count. Outputs after reset: dout=0, wr_ack=0, valid=0, wr_count=rd_count=0, empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not cleared.
- Reset asserted mid-operation discards all stored data and overrides any wr_en or rd_en in that cycle.
- State: write pointer, read pointer (log2(FIFO_DEPTH) bits each, wrapping modulo FIFO_DEPTH) and a count register (0..FIFO_DEPTH).
- Write accept = wr_en & ~full.
  - On accept: mem[wr_ptr] <= din, wr_ptr increments, wr_ack=1 in the next cycle.
  - A write while full is dropped: no state change, wr_ack=0.
- Read accept = rd_en & ~empty.
  - On accept: dout <= mem[rd_ptr], rd_ptr increments, valid=1 in the next cycle. Read latency is 1 clock.
  - A read while empty is ignored: valid=0 and dout holds its last value.
- Simultaneous write and read:
  - Both accepted: count unchanged, both pointers advance.
  - When full, the write is refused even if a read is accepted in the same cycle.
  - When empty, the read is refused even if a write is accepted; there is no fall-through.
- Count: +1 on write-only accept, -1 on read-only accept.
- full, empty, almost_full, almost_empty, wr_count and rd_count are combinational decodes of the registered count, so they update in the cycle after the accepted operation.
- din is truncated to DATA_WIDTH bits by the driver; the FIFO does no width handling.
- Data order is strictly first in, first out across pointer wrap-around.

Decomposition:
- No shared package is required; count width is a localparam CNT_W = $clog2(FIFO_DEPTH-1)+1 and pointer width is a localparam PTR_W = $clog2(FIFO_DEPTH).
- One sub-module, fifo_mem: simple dual-port register array with write port (we, waddr, wdata) and registered read port (re, raddr, rdata). Pointers, count, flags and the acknowledge/valid logic stay in async_fifo.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> empty=1, almost_empty=1, full=0, almost_full=0, counts=0, wr_ack=0, valid=0, dout=0.
- Overflow: write 17, 20, 800..807 (truncated to 8 bits) on 10 consecutive cycles ->
  - first 8 accepted (17, 20, 32..37), each followed by wr_ack=1;
  - almost_full rises when count reaches 6, full rises at 8;
  - the writes of 38 and 39 give wr_ack=0 and count stays 8.
- Drain and underflow: 14 back-to-back reads ->
  - valid=1 for 8 cycles with dout 17, 20, 32..37 in order;
  - almost_empty=1 once count <= 1, empty at 0;
  - the remaining 6 reads give valid=0 with dout held at 37.
- Wrap-around: write 1..10, then read 14 -> dout returns 1..8 in order (pointers wrapped); 9 and 10 are dropped with wr_ack=0.
- Simultaneous operations:
  - at count 4, wr_en=rd_en=1 for 3 cycles -> count stays 4, valid=1 and wr_ack=1 each cycle, order preserved;
  - at full, wr_en=rd_en=1 -> read only, wr_ack=0, count becomes 7.
- Reset mid-stream: with count 5, assert rst for one cycle alongside wr_en=1 -> count 0, empty=1, wr_ack=0; a subsequent read returns valid=0.
